// File: rtl/rat_pkg.sv
// Shared definitions for the RAT MCU control unit.
//   - FSM state encoding
//   - opcode constants
//   - ALU operation codes
//   - register-file write-data select codes
//   - the control-word struct driven by the decoder and the FSM
//   - a helper that builds the control word for a flag-setting ALU op
package rat_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

  // Register-register ops: full 7-bit opcode {HI_5, LO_2}
  localparam logic [6:0] OP_AND_R  = 7'b0000000;
  localparam logic [6:0] OP_OR_R   = 7'b0000001;
  localparam logic [6:0] OP_EXOR_R = 7'b0000010;
  localparam logic [6:0] OP_TEST_R = 7'b0000011;
  localparam logic [6:0] OP_ADD_R  = 7'b0000100;
  localparam logic [6:0] OP_ADDC_R = 7'b0000101;
  localparam logic [6:0] OP_SUB_R  = 7'b0000110;
  localparam logic [6:0] OP_SUBC_R = 7'b0000111;
  localparam logic [6:0] OP_CMP_R  = 7'b0001000;
  localparam logic [6:0] OP_MOV_R  = 7'b0001001;
  localparam logic [6:0] OP_LD_R   = 7'b0001010;
  localparam logic [6:0] OP_ST_R   = 7'b0001011;

  // Branches: full 7-bit opcode
  localparam logic [6:0] OP_BRN    = 7'b0010000;
  localparam logic [6:0] OP_BREQ   = 7'b0010010;
  localparam logic [6:0] OP_BRNE   = 7'b0010011;
  localparam logic [6:0] OP_BRCS   = 7'b0010100;
  localparam logic [6:0] OP_BRCC   = 7'b0010101;

  // Immediate ops: HI_5 only
  localparam logic [4:0] OP_AND_I  = 5'b10000;
  localparam logic [4:0] OP_OR_I   = 5'b10001;
  localparam logic [4:0] OP_EXOR_I = 5'b10010;
  localparam logic [4:0] OP_TEST_I = 5'b10011;
  localparam logic [4:0] OP_ADD_I  = 5'b10100;
  localparam logic [4:0] OP_ADDC_I = 5'b10101;
  localparam logic [4:0] OP_SUB_I  = 5'b10110;
  localparam logic [4:0] OP_SUBC_I = 5'b10111;
  localparam logic [4:0] OP_CMP_I  = 5'b11000;
  localparam logic [4:0] OP_IN_I   = 5'b11001;
  localparam logic [4:0] OP_OUT_I  = 5'b11010;
  localparam logic [4:0] OP_MOV_I  = 5'b11011;
  localparam logic [4:0] OP_LD_I   = 5'b11100;
  localparam logic [4:0] OP_ST_I   = 5'b11101;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_ADDC = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_SUBC = 4'b0011;
  localparam logic [3:0] ALU_CMP  = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_EXOR = 4'b0111;
  localparam logic [3:0] ALU_TEST = 4'b1000;
  localparam logic [3:0] ALU_MOV  = 4'b1110;

  // Register-file write-data mux select
  localparam logic [1:0] RF_SEL_ALU = 2'b00;
  localparam logic [1:0] RF_SEL_SCR = 2'b01;
  localparam logic [1:0] RF_SEL_IN  = 2'b11;

  typedef struct packed {
    logic       pc_rst;
    logic       pc_inc;
    logic       pc_ld;
    logic [1:0] pc_mux_sel;
    logic       alu_opy_sel;
    logic [3:0] alu_sel;
    logic       rf_wr;
    logic [1:0] rf_wr_sel;
    logic       scr_we;
    logic       scr_addr_sel;
    logic       flg_c_ld;
    logic       flg_z_ld;
    logic       io_strb;
  } ctrl_t;

  // Control word for an ALU op that loads both flags; wr=0 for CMP/TEST.
  function automatic ctrl_t alu_ctrl(input logic [3:0] sel, input logic wr);
    ctrl_t c;
    c           = '0;
    c.alu_sel   = sel;
    c.rf_wr     = wr;
    c.rf_wr_sel = RF_SEL_ALU;
    c.flg_c_ld  = 1'b1;
    c.flg_z_ld  = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/rat_decode.sv
// Combinational opcode decoder for the RAT MCU.
// Ports:
//   opcode_i  [6:0]  {OPCODE_HI_5, OPCODE_LO_2}
//   c_i, z_i         current carry / zero flags (branch conditions)
//   ctrl_o           control word for the EXEC cycle (pc_rst/pc_inc always 0)
//   illegal_o        opcode is not a recognised instruction; ctrl_o is all zero
module rat_decode
  import rat_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic       c_i,
  input  logic       z_i,
  output ctrl_t      ctrl_o,
  output logic       illegal_o
);

  // Opcode + flags to control word
  always_comb begin
    ctrl_o    = '0;
    illegal_o = 1'b0;
    if (opcode_i[6] == 1'b1) begin
      // Immediate class: LO_2 is part of the immediate and is ignored
      case (opcode_i[6:2])
        OP_AND_I:  ctrl_o = alu_ctrl(ALU_AND,  1'b1);
        OP_OR_I:   ctrl_o = alu_ctrl(ALU_OR,   1'b1);
        OP_EXOR_I: ctrl_o = alu_ctrl(ALU_EXOR, 1'b1);
        OP_TEST_I: ctrl_o = alu_ctrl(ALU_TEST, 1'b0);
        OP_ADD_I:  ctrl_o = alu_ctrl(ALU_ADD,  1'b1);
        OP_ADDC_I: ctrl_o = alu_ctrl(ALU_ADDC, 1'b1);
        OP_SUB_I:  ctrl_o = alu_ctrl(ALU_SUB,  1'b1);
        OP_SUBC_I: ctrl_o = alu_ctrl(ALU_SUBC, 1'b1);
        OP_CMP_I:  ctrl_o = alu_ctrl(ALU_CMP,  1'b0);
        OP_IN_I: begin
          ctrl_o.rf_wr     = 1'b1;
          ctrl_o.rf_wr_sel = RF_SEL_IN;
        end
        OP_OUT_I:  ctrl_o.io_strb = 1'b1;
        OP_MOV_I: begin
          ctrl_o.rf_wr   = 1'b1;
          ctrl_o.alu_sel = ALU_MOV;
        end
        OP_LD_I: begin
          ctrl_o.rf_wr        = 1'b1;
          ctrl_o.rf_wr_sel    = RF_SEL_SCR;
          ctrl_o.scr_addr_sel = 1'b1;
        end
        OP_ST_I: begin
          ctrl_o.scr_we       = 1'b1;
          ctrl_o.scr_addr_sel = 1'b1;
        end
        default:   illegal_o = 1'b1;
      endcase
      // Every decoded immediate op takes its Y operand from the instruction
      ctrl_o.alu_opy_sel = ~illegal_o;
    end else begin
      case (opcode_i)
        OP_AND_R:  ctrl_o = alu_ctrl(ALU_AND,  1'b1);
        OP_OR_R:   ctrl_o = alu_ctrl(ALU_OR,   1'b1);
        OP_EXOR_R: ctrl_o = alu_ctrl(ALU_EXOR, 1'b1);
        OP_TEST_R: ctrl_o = alu_ctrl(ALU_TEST, 1'b0);
        OP_ADD_R:  ctrl_o = alu_ctrl(ALU_ADD,  1'b1);
        OP_ADDC_R: ctrl_o = alu_ctrl(ALU_ADDC, 1'b1);
        OP_SUB_R:  ctrl_o = alu_ctrl(ALU_SUB,  1'b1);
        OP_SUBC_R: ctrl_o = alu_ctrl(ALU_SUBC, 1'b1);
        OP_CMP_R:  ctrl_o = alu_ctrl(ALU_CMP,  1'b0);
        OP_MOV_R: begin
          ctrl_o.rf_wr   = 1'b1;
          ctrl_o.alu_sel = ALU_MOV;
        end
        OP_LD_R: begin
          ctrl_o.rf_wr     = 1'b1;
          ctrl_o.rf_wr_sel = RF_SEL_SCR;
        end
        OP_ST_R:   ctrl_o.scr_we = 1'b1;
        // Branch target is always the immediate address (PC_MUX_SEL = 00)
        OP_BRN:    ctrl_o.pc_ld = 1'b1;
        OP_BREQ:   ctrl_o.pc_ld = z_i;
        OP_BRNE:   ctrl_o.pc_ld = ~z_i;
        OP_BRCS:   ctrl_o.pc_ld = c_i;
        OP_BRCC:   ctrl_o.pc_ld = ~c_i;
        default:   illegal_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/rat_control_unit.sv
// Multi-cycle control FSM for the RAT MCU: INIT -> (FETCH -> EXEC)*.
// Ports:
//   clk, RST_N                  clock; asynchronous active-low reset
//   OPCODE_HI_5, OPCODE_LO_2    instruction bits [17:13] and [1:0]
//   C, Z                        current carry / zero flags
//   PC_RST, PC_INC, PC_LD, PC_MUX_SEL     program-counter controls
//   ALU_OPY_SEL, ALU_SEL                  ALU operand / operation select
//   RF_WR, RF_WR_SEL                      register-file write enable / data select
//   SCR_WE, SCR_ADDR_SEL                  scratch-RAM write / address select
//   FLG_C_LD, FLG_Z_LD                    flag load enables
//   IO_STRB                               OUT-port strobe
//   ILL_OP                                sticky undecoded-opcode flag
// Outputs are a combinational function of the state (and the opcode in EXEC),
// so reset forces PC_RST=1 and all other controls to 0 with no clock edge.
module rat_control_unit
  import rat_pkg::*;
#(
  parameter int unsigned INIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       RST_N,
  input  logic [4:0] OPCODE_HI_5,
  input  logic [1:0] OPCODE_LO_2,
  input  logic       C,
  input  logic       Z,
  output logic       PC_RST,
  output logic       PC_INC,
  output logic       PC_LD,
  output logic [1:0] PC_MUX_SEL,
  output logic       ALU_OPY_SEL,
  output logic [3:0] ALU_SEL,
  output logic       RF_WR,
  output logic [1:0] RF_WR_SEL,
  output logic       SCR_WE,
  output logic       SCR_ADDR_SEL,
  output logic       FLG_C_LD,
  output logic       FLG_Z_LD,
  output logic       IO_STRB,
  output logic       ILL_OP
);

  localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       ill_op_q, ill_op_d;
  ctrl_t      dec_ctrl_s;
  logic       dec_illegal_s;
  ctrl_t      ctrl_s;

  rat_decode u_decode (
    .opcode_i  ({OPCODE_HI_5, OPCODE_LO_2}),
    .c_i       (C),
    .z_i       (Z),
    .ctrl_o    (dec_ctrl_s),
    .illegal_o (dec_illegal_s)
  );

  // State, init counter and sticky illegal-op flag
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_INIT;
      cnt_q    <= 4'd0;
      ill_op_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ill_op_q <= ill_op_d;
    end
  end

  // Next state and control outputs
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ill_op_d = ill_op_q;
    ctrl_s   = '0;
    case (state_q)
      ST_INIT: begin
        ctrl_s.pc_rst = 1'b1;
        if (cnt_q == INIT_LAST) begin
          state_d = ST_FETCH;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_FETCH: begin
        ctrl_s.pc_inc = 1'b1;
        state_d       = ST_EXEC;
      end
      ST_EXEC: begin
        // Decoder yields an all-zero word for undecoded opcodes
        ctrl_s  = dec_ctrl_s;
        state_d = ST_FETCH;
        if (dec_illegal_s) begin
          ill_op_d = 1'b1;
        end else begin
          ill_op_d = ill_op_q;
        end
      end
      default: begin
        // Unreachable encoding: recover through INIT
        ctrl_s.pc_rst = 1'b1;
        state_d       = ST_INIT;
        cnt_d         = 4'd0;
      end
    endcase
  end

  assign PC_RST       = ctrl_s.pc_rst;
  assign PC_INC       = ctrl_s.pc_inc;
  assign PC_LD        = ctrl_s.pc_ld;
  assign PC_MUX_SEL   = ctrl_s.pc_mux_sel;
  assign ALU_OPY_SEL  = ctrl_s.alu_opy_sel;
  assign ALU_SEL      = ctrl_s.alu_sel;
  assign RF_WR        = ctrl_s.rf_wr;
  assign RF_WR_SEL    = ctrl_s.rf_wr_sel;
  assign SCR_WE       = ctrl_s.scr_we;
  assign SCR_ADDR_SEL = ctrl_s.scr_addr_sel;
  assign FLG_C_LD     = ctrl_s.flg_c_ld;
  assign FLG_Z_LD     = ctrl_s.flg_z_ld;
  assign IO_STRB      = ctrl_s.io_strb;
  assign ILL_OP       = ill_op_q;

endmodule

// File: tb/tb_rat_control_unit.sv
// Self-checking bench for rat_control_unit: directed steps followed by
// random opcodes, each EXEC cycle compared with a table-driven reference
// model of the instruction set.
module tb_rat_control_unit;

  localparam int INIT_CYCLES = 3;

  // Mnemonic numbering; reg-reg opcodes 0..11 map onto 0..11 directly
  localparam int M_AND = 0,  M_OR = 1,   M_EXOR = 2, M_TEST = 3, M_ADD = 4;
  localparam int M_ADDC = 5, M_SUB = 6,  M_SUBC = 7, M_CMP = 8,  M_MOV = 9;
  localparam int M_LD = 10,  M_ST = 11,  M_IN = 12,  M_OUT = 13;
  localparam int M_BRN = 14, M_BREQ = 15, M_BRNE = 16, M_BRCS = 17, M_BRCC = 18;
  localparam int M_ILL = -1;

  // ALU_SEL for mnemonics 0..9 (AND..MOV)
  localparam logic [3:0] ALU_TAB [0:9] = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd0,
                                           4'd1, 4'd2, 4'd3, 4'd4, 4'd14};
  // Immediate HI_5 = 16..29 in listed order
  localparam int IMM_TAB [0:13] = '{M_AND, M_OR, M_EXOR, M_TEST, M_ADD, M_ADDC,
                                    M_SUB, M_SUBC, M_CMP, M_IN, M_OUT, M_MOV,
                                    M_LD, M_ST};

  localparam logic [17:0] RST_WORD   = 18'h20000;
  localparam logic [17:0] FETCH_WORD = 18'h10000;

  logic       clk = 1'b0;
  logic       RST_N;
  logic [4:0] OPCODE_HI_5;
  logic [1:0] OPCODE_LO_2;
  logic       C, Z;
  logic       PC_RST, PC_INC, PC_LD, ALU_OPY_SEL, RF_WR, SCR_WE, SCR_ADDR_SEL;
  logic       FLG_C_LD, FLG_Z_LD, IO_STRB, ILL_OP;
  logic [1:0] PC_MUX_SEL, RF_WR_SEL;
  logic [3:0] ALU_SEL;

  int n_checks = 0;
  int n_fail   = 0;
  logic ill_model = 1'b0;

  rat_control_unit #(.INIT_CYCLES(INIT_CYCLES)) dut (
    .clk(clk), .RST_N(RST_N), .OPCODE_HI_5(OPCODE_HI_5), .OPCODE_LO_2(OPCODE_LO_2),
    .C(C), .Z(Z), .PC_RST(PC_RST), .PC_INC(PC_INC), .PC_LD(PC_LD),
    .PC_MUX_SEL(PC_MUX_SEL), .ALU_OPY_SEL(ALU_OPY_SEL), .ALU_SEL(ALU_SEL),
    .RF_WR(RF_WR), .RF_WR_SEL(RF_WR_SEL), .SCR_WE(SCR_WE), .SCR_ADDR_SEL(SCR_ADDR_SEL),
    .FLG_C_LD(FLG_C_LD), .FLG_Z_LD(FLG_Z_LD), .IO_STRB(IO_STRB), .ILL_OP(ILL_OP)
  );

  always #5 clk = ~clk;

  wire [17:0] obs_word = {PC_RST, PC_INC, PC_LD, PC_MUX_SEL, ALU_OPY_SEL, ALU_SEL,
                          RF_WR, RF_WR_SEL, SCR_WE, SCR_ADDR_SEL, FLG_C_LD,
                          FLG_Z_LD, IO_STRB};

  function automatic int mnem_of(input logic [6:0] op);
    int v;
    int hi;
    v  = int'(op);
    hi = int'(op[6:2]);
    if (v <= 11) return v;
    if (v == 16) return M_BRN;
    if (v == 18) return M_BREQ;
    if (v == 19) return M_BRNE;
    if (v == 20) return M_BRCS;
    if (v == 21) return M_BRCC;
    if (hi >= 16 && hi <= 29) return IMM_TAB[hi - 16];
    return M_ILL;
  endfunction

  function automatic logic [17:0] ref_word(input logic [6:0] op, input logic c, input logic z);
    int m;
    logic imm, is_alu, rf_wr, scr_we, sas, io, taken;
    logic [3:0] alu;
    logic [1:0] sel;
    m = mnem_of(op);
    if (m == M_ILL) return 18'h0;
    imm    = op[6];
    is_alu = (m <= M_CMP);
    alu    = (m <= M_MOV) ? ALU_TAB[m] : 4'd0;
    rf_wr  = (is_alu && m != M_TEST && m != M_CMP) || m == M_MOV || m == M_LD || m == M_IN;
    sel    = (m == M_LD) ? 2'b01 : ((m == M_IN) ? 2'b11 : 2'b00);
    scr_we = (m == M_ST);
    sas    = (m == M_LD || m == M_ST) && imm;
    io     = (m == M_OUT);
    taken  = (m == M_BRN) || (m == M_BREQ && z) || (m == M_BRNE && !z) ||
             (m == M_BRCS && c) || (m == M_BRCC && !c);
    return {1'b0, 1'b0, taken, 2'b00, imm, alu, rf_wr, sel, scr_we, sas,
            is_alu, is_alu, io};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One instruction: FETCH cycle (opcode randomised to show it is ignored), then EXEC
  task automatic run_instr(input logic [6:0] op, input logic c, input logic z);
    @(negedge clk);
    OPCODE_HI_5 = 5'($urandom);
    OPCODE_LO_2 = 2'($urandom);
    C = 1'($urandom);
    Z = 1'($urandom);
    #1;
    check("fetch_word", 32'(obs_word), 32'(FETCH_WORD));
    check("fetch_ill", 32'(ILL_OP), 32'(ill_model));
    OPCODE_HI_5 = op[6:2];
    OPCODE_LO_2 = op[1:0];
    C = c;
    Z = z;
    @(negedge clk);
    check($sformatf("exec_word op=%b c=%0b z=%0b", op, c, z), 32'(obs_word), 32'(ref_word(op, c, z)));
    check("exec_ill", 32'(ILL_OP), 32'(ill_model));
    check("rfwr_and_scrwe", 32'(RF_WR & SCR_WE), 32'd0);
    if (mnem_of(op) == M_ILL) ill_model = 1'b1;
  endtask

  task automatic reset_and_init();
    repeat (3) begin
      @(negedge clk);
      check("reset_word", 32'(obs_word), 32'(RST_WORD));
      check("reset_ill", 32'(ILL_OP), 32'd0);
    end
    RST_N = 1'b1;
    #1;
    check("init_word_0", 32'(obs_word), 32'(RST_WORD));
    for (int i = 1; i < INIT_CYCLES; i++) begin
      @(negedge clk);
      check($sformatf("init_word_%0d", i), 32'(obs_word), 32'(RST_WORD));
    end
  endtask

  initial begin
    logic [6:0] op;
    RST_N = 1'b0;
    OPCODE_HI_5 = 5'd0;
    OPCODE_LO_2 = 2'd0;
    C = 1'b0;
    Z = 1'b0;
    reset_and_init();

    // Directed steps
    run_instr(7'b0000100, 1'b0, 1'b0);            // ADD reg
    run_instr({5'b11000, 2'b10}, 1'b1, 1'b1);     // CMP imm
    run_instr(7'b0010010, 1'b0, 1'b1);            // BREQ taken
    run_instr(7'b0010010, 1'b1, 1'b0);            // BREQ not taken
    run_instr(7'b0001010, 1'b0, 1'b0);            // LD reg
    run_instr({5'b11101, 2'b01}, 1'b0, 1'b0);     // ST imm
    run_instr({5'b11010, 2'b11}, 1'b0, 1'b0);     // OUT
    run_instr({5'b11001, 2'b00}, 1'b0, 1'b0);     // IN
    run_instr(7'b0010101, 1'b0, 1'b1);            // BRCC taken
    run_instr(7'b0010100, 1'b0, 1'b1);            // BRCS not taken

    // Random decoded opcodes
    for (int n = 0; n < 150; n++) begin
      op = 7'($urandom);
      for (int t = 0; t < 50 && mnem_of(op) == M_ILL; t++) op = 7'($urandom);
      run_instr(op, 1'($urandom), 1'($urandom));
    end

    // Undecoded opcode, then ILL_OP must stick
    run_instr(7'b1111111, 1'b1, 1'b1);
    run_instr(7'b0000000, 1'b0, 1'b0);
    for (int n = 0; n < 40; n++) run_instr(7'($urandom), 1'($urandom), 1'($urandom));

    // Reset dropped mid-EXEC with RF_WR active acts without a clock edge
    run_instr(7'b0000100, 1'b0, 1'b0);
    RST_N = 1'b0;
    ill_model = 1'b0;
    #1;
    check("async_rst_word", 32'(obs_word), 32'(RST_WORD));
    check("async_rst_rfwr", 32'(RF_WR), 32'd0);
    check("async_rst_ill", 32'(ILL_OP), 32'd0);
    reset_and_init();
    run_instr(7'b0001001, 1'b0, 1'b0);            // MOV reg after re-init
    run_instr({5'b11011, 2'b10}, 1'b0, 1'b0);     // MOV imm

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
